uart_boot_sequencer: RTL
========================

// Module: uart_boot_sequencer
// PURPOSE
//  CPU-side boot controller that owns the UART RX/TX pair after reset. It runs the host boot protocol:
//  send 0x99, receive a 4-byte program length and the program image, write the image word-by-word
//  into instruction memory, send 0xAA. It then releases the core, hands the UART to the CPU and
//  schedules all TX bytes through a single tx_start/tx_busy handshake.
// PARAMETERS
//  IMEM_ADDR_W     14         instruction memory word-address width
//  MAX_PROG_BYTES  65536      largest accepted program length in bytes (must be <= 4<<IMEM_ADDR_W)
//  SYNC_BYTE       8'h99      byte sent to request the program
//  DONE_BYTE       8'hAA      byte sent after the last program word is written
// PORTS
//  clk            in   1            system clock
//  reset_n        in   1            asynchronous active-low reset
//  rx_rdata       in   8            byte from UART_RX
//  rx_rdata_ready in   1            1-cycle strobe: rx_rdata valid
//  rx_ferr        in   1            framing error, qualified by rx_rdata_ready
//  tx_sdata       out  8            byte to UART_TX
//  tx_start       out  1            1-cycle launch strobe to UART_TX
//  tx_busy        in   1            UART_TX busy (asserts the cycle after tx_start)
//  imem_we        out  1            instruction memory write strobe
//  imem_addr      out  IMEM_ADDR_W  word address
//  imem_wdata     out  32           little-endian assembled word
//  boot_done      out  1            level: program loaded, core may run
//  boot_err       out  1            level: boot aborted (oversize length or framing error)
//  cpu_tx_req     in   1            CPU holds high with cpu_tx_data stable until ack
//  cpu_tx_data    in   8            CPU output byte
//  cpu_tx_ack     out  1            1-cycle: cpu_tx_data launched
//  cpu_rx_valid   out  1            1-cycle: cpu_rx_data valid (RUN state only)
//  cpu_rx_data    out  8            received byte for CPU
// BEHAVIOUR
//  Reset (any time, async): all outputs 0, state SEND_SYNC, counters cleared; a boot in progress is abandoned.
//  TX launch rule: tx_start only when tx_busy=0 and tx_start was 0 last cycle (guard cycle covers
//   tx_busy latency); tx_sdata is registered in the same cycle as tx_start and held until the next launch.
//  States:
//   SEND_SYNC : launch SYNC_BYTE once -> RECV_SIZE. RX bytes in this state are dropped.
//   RECV_SIZE : take 4 bytes little-endian into len[31:0]. After byte 4: len==0 -> SEND_DONE;
//               len>MAX_PROG_BYTES -> ERR; else -> RECV_PROG.
//   RECV_PROG : byte k goes into word lane k%4 (lane 0 = bits 7:0). On lane 3, or on the final byte,
//               imem_we pulses the cycle after the byte strobe, unused lanes zero, addr = k/4 (from 0).
//               After byte len-1 is written -> SEND_DONE.
//   SEND_DONE : launch DONE_BYTE -> RUN; boot_done rises the cycle tx_start is issued.
//   RUN       : each rx_rdata_ready forwarded: cpu_rx_valid/cpu_rx_data registered, latency 1 cycle;
//               rx_ferr bytes are dropped. When cpu_tx_req=1 and the launch rule allows, tx_sdata<=cpu_tx_data,
//               tx_start=1 and cpu_tx_ack=1 in the same cycle; at most one launch every 2 cycles.
//   ERR       : boot_err=1, no TX, no imem writes, RX ignored; exits only on reset.
//  Framing error (rx_ferr with rx_rdata_ready) in RECV_SIZE/RECV_PROG -> ERR.
//  Byte counter 32 bit; imem_addr wraps never (length bound enforces it). boot_done/boot_err mutually exclusive.
//  imem_we and RX strobe on the same cycle: the write uses the completed word; the new byte goes to the next word.
// TESTING
//  1 reset release -> one tx_start with tx_sdata=0x99 within 2 cycles; no further TX until size received.
//  2 size 08 00 00 00, bytes 01..08 -> imem writes addr0=0x04030201, addr1=0x08070605; then TX 0xAA, boot_done=1.
//  3 size 05 00 00 00, bytes AA BB CC DD EE -> addr0=0xDDCCBBAA, addr1=0x000000EE; then 0xAA.
//  4 size 00 00 00 00 -> no imem_we, 0xAA sent; size > MAX_PROG_BYTES -> boot_err=1, no 0xAA.
//  5 rx_ferr during program bytes -> boot_err=1, writes stop; reset_n low mid-load -> restart with 0x99.
//  6 RUN: cpu_tx_req held with 0x41 while tx_busy toggles -> exactly one ack per launch, none while busy;
//    RX byte 0x5A -> cpu_rx_valid 1 cycle later with data 0x5A.

Source files
------------

// File: rtl/uart_boot_sequencer.sv
// uart_boot_sequencer: owns the UART after reset, loads the program image into
// instruction memory over the host boot protocol, then bridges the UART to the CPU.
//
// state      | meaning
// SEND_SYNC  | launch SYNC_BYTE to request the image
// RECV_SIZE  | collect the 4-byte little-endian program length
// RECV_PROG  | pack image bytes into words and write imem
// SEND_DONE  | launch DONE_BYTE and raise boot_done
// RUN        | UART bridged to the CPU
// ERR        | boot aborted, held until reset
module uart_boot_sequencer #(
  parameter int unsigned IMEM_ADDR_W    = 14,
  parameter int unsigned MAX_PROG_BYTES = 65536,
  parameter logic [7:0]  SYNC_BYTE      = 8'h99,
  parameter logic [7:0]  DONE_BYTE      = 8'hAA
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_rdata,
  input  logic                   rx_rdata_ready,
  input  logic                   rx_ferr,
  output logic [7:0]             tx_sdata,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   boot_done,
  output logic                   boot_err,
  input  logic                   cpu_tx_req,
  input  logic [7:0]             cpu_tx_data,
  output logic                   cpu_tx_ack,
  output logic                   cpu_rx_valid,
  output logic [7:0]             cpu_rx_data
);

  typedef enum logic [2:0] {
    S_SEND_SYNC,
    S_RECV_SIZE,
    S_RECV_PROG,
    S_SEND_DONE,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(MAX_PROG_BYTES);

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            len_q, len_d;
  logic [31:0]            word_q, word_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_sdata_q, tx_sdata_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]            imem_wdata_q, imem_wdata_d;
  logic                   boot_done_q, boot_done_d;
  logic                   boot_err_q, boot_err_d;
  logic                   cpu_tx_ack_q, cpu_tx_ack_d;
  logic                   cpu_rx_valid_q, cpu_rx_valid_d;
  logic [7:0]             cpu_rx_data_q, cpu_rx_data_d;

  logic        rx_ok;
  logic        rx_bad;
  logic        can_launch;
  logic        last_byte;
  logic [1:0]  lane;
  logic [31:0] len_shift;
  logic [31:0] word_new;

  // tx_start_q blocks a back-to-back launch while tx_busy is still catching up
  always_comb begin
    rx_ok      = rx_rdata_ready & ~rx_ferr;
    rx_bad     = rx_rdata_ready & rx_ferr;
    can_launch = ~tx_busy & ~tx_start_q;
    lane       = cnt_q[1:0];
    len_shift  = {rx_rdata, len_q[31:8]};
    word_new   = ((lane == 2'd0) ? 32'h0 : word_q) | ({24'h0, rx_rdata} << {lane, 3'b000});
    last_byte  = (cnt_q == (len_q - 32'd1));
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    word_d         = word_q;
    tx_start_d     = 1'b0;
    tx_sdata_d     = tx_sdata_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    boot_done_d    = boot_done_q;
    boot_err_d     = boot_err_q;
    cpu_tx_ack_d   = 1'b0;
    cpu_rx_valid_d = 1'b0;
    cpu_rx_data_d  = cpu_rx_data_q;

    unique case (state_q)
      S_SEND_SYNC: begin
        if (can_launch) begin
          tx_start_d = 1'b1;
          tx_sdata_d = SYNC_BYTE;
          cnt_d      = 32'd0;
          state_d    = S_RECV_SIZE;
        end
      end

      S_RECV_SIZE: begin
        if (rx_bad) begin
          state_d = S_ERR;
        end else if (rx_ok) begin
          len_d = len_shift;
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'd3) begin
            cnt_d = 32'd0;
            if (len_shift == 32'd0) begin
              state_d = S_SEND_DONE;
            end else if (len_shift > MAX_LEN) begin
              state_d = S_ERR;
            end else begin
              state_d = S_RECV_PROG;
            end
          end
        end
      end

      S_RECV_PROG: begin
        if (rx_bad) begin
          state_d = S_ERR;
        end else if (rx_ok) begin
          word_d = word_new;
          cnt_d  = cnt_q + 32'd1;
          // the completed word is registered directly, so a strobe on the
          // write cycle starts a fresh word from lane 0
          if ((lane == 2'd3) || last_byte) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = cnt_q[IMEM_ADDR_W+1:2];
            imem_wdata_d = word_new;
          end
          if (last_byte) begin
            state_d = S_SEND_DONE;
          end
        end
      end

      S_SEND_DONE: begin
        if (can_launch) begin
          tx_start_d  = 1'b1;
          tx_sdata_d  = DONE_BYTE;
          boot_done_d = 1'b1;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        if (rx_ok) begin
          cpu_rx_valid_d = 1'b1;
          cpu_rx_data_d  = rx_rdata;
        end
        if (cpu_tx_req && can_launch) begin
          tx_start_d   = 1'b1;
          tx_sdata_d   = cpu_tx_data;
          cpu_tx_ack_d = 1'b1;
        end
      end

      S_ERR: begin
        boot_err_d = 1'b1;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    if (state_d == S_ERR) begin
      boot_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_SEND_SYNC;
      cnt_q          <= 32'd0;
      len_q          <= 32'd0;
      word_q         <= 32'd0;
      tx_start_q     <= 1'b0;
      tx_sdata_q     <= 8'h00;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= 32'd0;
      boot_done_q    <= 1'b0;
      boot_err_q     <= 1'b0;
      cpu_tx_ack_q   <= 1'b0;
      cpu_rx_valid_q <= 1'b0;
      cpu_rx_data_q  <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      word_q         <= word_d;
      tx_start_q     <= tx_start_d;
      tx_sdata_q     <= tx_sdata_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      boot_done_q    <= boot_done_d;
      boot_err_q     <= boot_err_d;
      cpu_tx_ack_q   <= cpu_tx_ack_d;
      cpu_rx_valid_q <= cpu_rx_valid_d;
      cpu_rx_data_q  <= cpu_rx_data_d;
    end
  end

  assign tx_sdata     = tx_sdata_q;
  assign tx_start     = tx_start_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign boot_done    = boot_done_q;
  assign boot_err     = boot_err_q;
  assign cpu_tx_ack   = cpu_tx_ack_q;
  assign cpu_rx_valid = cpu_rx_valid_q;
  assign cpu_rx_data  = cpu_rx_data_q;

endmodule
